// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: synchronizes div_clk, emits edge strobes, measures
// period/high time in clk cycles and tracks lock against the expected ratio.
module clk_div_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8,
   parameter int EXP_PERIOD  = 3,
   parameter int TOL         = 0,
   parameter int LOCK_CNT    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             div_clk,
   input  logic             err_clr,
   output logic             rise,
   output logic             fall,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             period_valid,
   output logic             locked,
   output logic             err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam int GC_W = $clog2(LOCK_CNT + 1);

   typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // Distance compare done in 32-bit unsigned with the larger operand first.
   function automatic logic is_good(input logic [CNT_W-1:0] v);
      logic [31:0] a;
      logic [31:0] e;
      a = 32'(v);
      e = 32'(EXP_PERIOD);
      if (a >= e) return (a - e) <= 32'(TOL);
      else        return (e - a) <= 32'(TOL);
   endfunction

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   s_d;
   logic                   rise_p0;
   logic                   fall_p0;
   logic                   tmo_p0;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       m_p0;
   logic                   seen;
   logic                   good_p1;
   logic                   err_set;
   state_t                 state;
   logic [GC_W-1:0]        good_cnt;

   // Stage p0: synchronized level, edge detect, running count
   assign s       = sync_q[SYNC_STAGES-1];
   assign rise_p0 = s & ~s_d;
   assign fall_p0 = ~s & s_d;
   assign m_p0    = sat_inc(cnt);
   assign tmo_p0  = (cnt == CNT_MAX) && !rise_p0;

   always_ff @(posedge clk) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], div_clk};
   end

   // Stage p1: registered strobes and measurements
   always_ff @(posedge clk) begin
      if (reset) begin
         s_d          <= 1'b0;
         cnt          <= '0;
         seen         <= 1'b0;
         good_p1      <= 1'b0;
         rise         <= 1'b0;
         fall         <= 1'b0;
         period       <= '0;
         high_time    <= '0;
         period_valid <= 1'b0;
      end else begin
         s_d          <= s;
         rise         <= rise_p0;
         fall         <= fall_p0;
         period_valid <= 1'b0;
         if (rise_p0) begin
            cnt     <= '0;
            seen    <= 1'b1;
            good_p1 <= is_good(m_p0);
            // A saturated count is a lost acquisition, never a period.
            if (seen && cnt != CNT_MAX) begin
               period       <= m_p0;
               period_valid <= 1'b1;
            end
         end else begin
            cnt <= sat_inc(cnt);
            if (tmo_p0) seen <= 1'b0;
         end
         if (fall_p0 && seen) high_time <= m_p0;
      end
   end

   // Stage p2: lock state machine driven by the p1 strobes
   assign err_set = (state == LOCKED) &&
                    ((rise && !(period_valid && good_p1)) || (!rise && tmo_p0));

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= UNLOCKED;
         good_cnt <= '0;
         locked   <= 1'b0;
         err      <= 1'b0;
      end else begin
         if (err_set)      err <= 1'b1;
         else if (err_clr) err <= 1'b0;

         if (rise) begin
            case (state)
               UNLOCKED: begin
                  state    <= ACQUIRE;
                  good_cnt <= '0;
                  locked   <= 1'b0;
               end
               ACQUIRE: begin
                  if (period_valid && good_p1) begin
                     if (good_cnt >= GC_W'(LOCK_CNT - 1)) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                     end
                     good_cnt <= good_cnt + GC_W'(1);
                  end else begin
                     good_cnt <= '0;
                  end
               end
               LOCKED: begin
                  if (!(period_valid && good_p1)) begin
                     state    <= ACQUIRE;
                     good_cnt <= '0;
                     locked   <= 1'b0;
                  end
               end
               default: begin
                  state    <= UNLOCKED;
                  good_cnt <= '0;
                  locked   <= 1'b0;
               end
            endcase
         end else if (tmo_p0) begin
            state    <= UNLOCKED;
            good_cnt <= '0;
            locked   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: clk-aligned div_clk patterns with
// hand-computed strobe, measurement, lock and error expectations.
module tb_clk_div_monitor;

   logic       clk = 1'b0;
   logic       reset;
   logic       div_clk;
   logic       err_clr;
   logic       rise;
   logic       fall;
   logic [7:0] period;
   logic [7:0] high_time;
   logic       period_valid;
   logic       locked;
   logic       err;

   int n_cmp = 0;
   int n_bad = 0;
   int n_pv = 0;
   int width_viol = 0;
   int coinc_viol = 0;
   logic rise_d = 1'b0;
   logic fall_d = 1'b0;
   logic pv_d = 1'b0;
   int base_pv;
   int pv_snap;

   clk_div_monitor #(
      .SYNC_STAGES(2),
      .CNT_W(8),
      .EXP_PERIOD(3),
      .TOL(0),
      .LOCK_CNT(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .div_clk(div_clk),
      .err_clr(err_clr),
      .rise(rise),
      .fall(fall),
      .period(period),
      .high_time(high_time),
      .period_valid(period_valid),
      .locked(locked),
      .err(err)
   );

   always #5 clk = ~clk;

   // Pulse bookkeeping on the inactive edge
   always @(negedge clk) begin
      n_pv   <= n_pv + (period_valid ? 1 : 0);
      if ((rise && rise_d) || (fall && fall_d) || (period_valid && pv_d))
         width_viol <= width_viol + 1;
      if (period_valid && !rise) coinc_viol <= coinc_viol + 1;
      rise_d <= rise;
      fall_d <= fall;
      pv_d   <= period_valid;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input logic v);
      div_clk = v;
      @(posedge clk);
      #1;
   endtask

   task automatic per(input int hi, input int lo);
      repeat (hi) tick(1'b1);
      repeat (lo) tick(1'b0);
   endtask

   initial begin
      reset   = 1'b1;
      div_clk = 1'b0;
      err_clr = 1'b0;
      repeat (3) tick(1'b0);
      chk("rst_flags", 32'({rise, fall, period_valid, locked, err}), 0);
      chk("rst_period", 32'(period), 0);
      chk("rst_high", 32'(high_time), 0);
      reset = 1'b0;
      tick(1'b0);
      tick(1'b0);
      base_pv = n_pv;

      // Ideal /3 stream and lock acquisition
      tick(1'b1);
      chk("lat_t1", 32'(rise), 0);
      tick(1'b1);
      chk("lat_t2", 32'(rise), 0);
      tick(1'b0);
      chk("lat_rise", 32'(rise), 1);
      chk("first_pv", 32'(period_valid), 0);
      for (int i = 0; i < 3; i++) begin
         per(2, 1);
         chk("p3_period", 32'(period), 3);
         chk("p3_pv", 32'(period_valid), 1);
      end
      chk("p3_high", 32'(high_time), 2);
      per(2, 1);
      chk("pre_lock", 32'(locked), 0);
      tick(1'b1);
      chk("lock", 32'(locked), 1);
      chk("lock_err", 32'(err), 0);
      tick(1'b1);
      tick(1'b0);

      // One stretched period while locked, then relock
      tick(1'b1);
      chk("pv_count", n_pv - base_pv, 5);
      tick(1'b1);
      tick(1'b0);
      tick(1'b0);
      per(2, 1);
      chk("stretch_period", 32'(period), 4);
      chk("stretch_pv", 32'(period_valid), 1);
      chk("stretch_lock_hold", 32'(locked), 1);
      tick(1'b1);
      chk("stretch_unlock", 32'(locked), 0);
      chk("stretch_err", 32'(err), 1);
      tick(1'b1);
      tick(1'b0);
      for (int i = 0; i < 3; i++) per(2, 1);
      chk("relock_pre", 32'(locked), 0);
      tick(1'b1);
      chk("relock", 32'(locked), 1);
      tick(1'b1);
      tick(1'b0);

      // err_clr coincident with a new error, then alone
      per(2, 2);
      per(2, 1);
      chk("bad2_period", 32'(period), 4);
      err_clr = 1'b1;
      tick(1'b1);
      chk("clr_vs_set", 32'(err), 1);
      chk("bad2_unlock", 32'(locked), 0);
      tick(1'b1);
      chk("clr_alone", 32'(err), 0);
      err_clr = 1'b0;
      tick(1'b0);
      for (int i = 0; i < 3; i++) per(2, 1);
      tick(1'b1);
      chk("lock3", 32'(locked), 1);
      tick(1'b1);
      tick(1'b0);

      // Long low hold forces a counter timeout
      tick(1'b0);
      pv_snap = n_pv;
      repeat (299) tick(1'b0);
      chk("tmo_locked", 32'(locked), 0);
      chk("tmo_err", 32'(err), 1);
      chk("tmo_period", 32'(period), 3);
      chk("tmo_no_pv", n_pv - pv_snap, 0);
      per(2, 1);
      chk("resume_rise", 32'(rise), 1);
      chk("resume_pv", 32'(period_valid), 0);

      // Reset pulse in ACQUIRE with two good periods counted
      per(2, 1);
      per(2, 1);
      chk("acq_locked", 32'(locked), 0);
      tick(1'b1);
      reset = 1'b1;
      tick(1'b1);
      chk("mid_rst_flags", 32'({rise, fall, period_valid, locked, err}), 0);
      chk("mid_rst_period", 32'(period), 0);
      chk("mid_rst_high", 32'(high_time), 0);
      reset = 1'b0;
      tick(1'b0);
      per(2, 1);
      chk("post_rst_rise", 32'(rise), 1);
      chk("post_rst_pv", 32'(period_valid), 0);
      for (int i = 0; i < 4; i++) per(2, 1);
      chk("post_rst_prelock", 32'(locked), 0);
      tick(1'b1);
      chk("post_rst_lock", 32'(locked), 1);
      tick(1'b1);
      tick(1'b0);

      // Single-cycle glitch while locked
      per(1, 1);
      per(2, 1);
      chk("glitch_period", 32'(period), 2);
      chk("glitch_pv", 32'(period_valid), 1);
      chk("glitch_high", 32'(high_time), 1);
      chk("glitch_lock_hold", 32'(locked), 1);
      chk("glitch_err_pre", 32'(err), 0);
      tick(1'b1);
      chk("glitch_unlock", 32'(locked), 0);
      chk("glitch_err", 32'(err), 1);
      tick(1'b1);
      tick(1'b0);
      tick(1'b0);
      tick(1'b0);
      chk("strobe_width", width_viol, 0);
      chk("pv_coincident", coinc_viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
